// File: rtl/bitrev_reorder_buffer_if.sv
// Streaming bundle for the bit-reversal reorder buffer: frame-size config,
// natural-order input stream and bit-reversed output stream.
interface bitrev_reorder_buffer_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        log_n_cfg;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Coefficient source / butterfly side
  modport master (
    output log_n_cfg, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Reorder buffer side
  modport slave (
    input  log_n_cfg, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bitrev_reorder_buffer.sv
// Single-buffered frame store: loads 2^k coefficients in natural order, then
// replays them in bit-reversed index order. Load and drain never overlap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_LOAD  | accepting input words into mem[wr_cnt], output idle
// S_DRAIN | presenting mem[rev_k(rd_cnt)], input held off
module bitrev_reorder_buffer #(
  parameter int DATA_W = 8,
  parameter int LOG_N  = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  bitrev_reorder_buffer_if.slave bus
);
  localparam int N_MAX = 1 << LOG_N;
  localparam int CW    = LOG_N + 1;

  localparam logic [0:0] S_LOAD  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]        state_q;
  logic [DATA_W-1:0] mem [N_MAX];
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_cnt;
  logic [CW-1:0]     k_q;

  logic [CW-1:0]     k_cfg;
  logic [CW-1:0]     k_wr;
  logic [CW-1:0]     wr_last;
  logic [CW-1:0]     rd_last;
  logic [LOG_N-1:0]  rd_rev_full;
  logic [LOG_N-1:0]  rd_idx;
  logic              in_ready_i;
  logic              out_valid_i;
  logic              in_fire;
  logic              out_fire;

  assign in_ready_i  = (state_q == S_LOAD);
  assign out_valid_i = (state_q == S_DRAIN);
  assign in_fire     = bus.in_valid & in_ready_i;
  assign out_fire    = out_valid_i & bus.out_ready;

  // Frame-size clamp; the first word of a frame already uses the new size,
  // so the write side looks at the live config while wr_cnt is zero.
  always_comb begin
    k_cfg = CW'(LOG_N);
    if (bus.log_n_cfg != 8'd0 && bus.log_n_cfg <= 8'(LOG_N)) begin
      k_cfg = CW'(bus.log_n_cfg);
    end
    k_wr    = (wr_cnt == '0) ? k_cfg : k_q;
    wr_last = CW'((1 << k_wr) - 1);
    rd_last = CW'((1 << k_q) - 1);
  end

  // Reverse the low k bits of rd_cnt: full-width reversal, then drop the
  // (LOG_N - k) bits that came from the always-zero top of the counter.
  always_comb begin
    rd_rev_full = '0;
    for (int b = 0; b < LOG_N; b++) begin
      rd_rev_full[b] = rd_cnt[LOG_N-1-b];
    end
    rd_idx = rd_rev_full >> (CW'(LOG_N) - k_q);
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_data  = out_valid_i ? mem[rd_idx] : '0;
  assign bus.out_last  = out_valid_i && (rd_cnt == rd_last);

  // Load/drain sequencing with write/read index counters and latched size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      k_q     <= CW'(LOG_N);
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_fire) begin
            if (wr_cnt == '0) begin
              k_q <= k_cfg;
            end
            if (wr_cnt == wr_last) begin
              wr_cnt  <= '0;
              state_q <= S_DRAIN;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (rd_cnt == rd_last) begin
              rd_cnt  <= '0;
              state_q <= S_LOAD;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Coefficient store; cleared on reset so a discarded frame leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_MAX; i++) begin
        mem[i] <= '0;
      end
    end else if (in_fire) begin
      mem[wr_cnt[LOG_N-1:0]] <= bus.in_data;
    end
  end
endmodule

// File: doc/bitrev_reorder_buffer.md
Name: bitrev_reorder_buffer

Overview:
- Frame buffer that accepts one frame of NTT coefficients in natural index order and replays it in bit-reversed index order.
- Sits directly downstream of the per-index bit-reversal logic, between the coefficient source and the butterfly stage of the naive forward NTT.
- Uses valid/ready streaming on both sides with a runtime frame size of 2^log_n_cfg.

Parameters:
- DATA_W, 8, coefficient width in bits.
- LOG_N, 3, log2 of the maximum frame length. Buffer depth is N_MAX = 2^LOG_N.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- log_n_cfg  input  8  log2 of the frame length. Sampled only on the first accepted input word of a frame.
- in_valid  input  1  upstream has a coefficient on in_data.
- in_ready  output  1  block can accept a coefficient.
- in_data  input  DATA_W  coefficient, natural order.
- out_valid  output  1  out_data holds a valid reordered coefficient.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DATA_W  coefficient, bit-reversed order.
- out_last  output  1  high with the final word of the frame.

Behaviour:
- Storage:
  - N_MAX x DATA_W register array.
  - Write counter wr_cnt and read counter rd_cnt, each LOG_N+1 bits.
  - Latched frame size k (LOG_N+1 bits). Frame length L = 2^k.
- FSM has two states: LOAD and DRAIN. Reset state is LOAD.
- LOAD:
  - in_ready = 1, out_valid = 0.
  - Input handshake = in_valid & in_ready.
  - On a handshake, in_data is written to mem[wr_cnt] and wr_cnt increments.
  - On the handshake with wr_cnt == 0, k latches the clamped log_n_cfg and that same word uses the new L.
  - Clamp rule: log_n_cfg == 0 or log_n_cfg > LOG_N gives k = LOG_N.
  - On the handshake with wr_cnt == L-1: next state is DRAIN, wr_cnt = 0.
- DRAIN:
  - in_ready = 0, out_valid = 1.
  - out_data = mem[rev_k(rd_cnt)], where rev_k reverses the low k bits of rd_cnt; upper bits are 0.
  - out_data is a combinational read of registered state and stays stable while out_valid & !out_ready.
  - out_last = (rd_cnt == L-1).
  - Output handshake = out_valid & out_ready, which increments rd_cnt.
  - Handshake with out_last: next state is LOAD, rd_cnt = 0.
- Latency:
  - First out_valid is the cycle after the last input handshake.
  - in_ready returns the cycle after the last output handshake.
  - A fully streaming frame of L words therefore takes 2L cycles.
- No overlap between load and drain (single buffer). in_valid during DRAIN is ignored and must be held by upstream.
- log_n_cfg changes mid-frame have no effect until the next frame's first word.
- out_ready held low in DRAIN stalls indefinitely with no data loss.
- Reset, including mid-frame:
  - state = LOAD, wr_cnt = rd_cnt = 0, k = LOG_N, mem cleared to 0.
  - Immediately in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
  - Any partial frame is discarded.
- Outputs while in LOAD: out_data = 0, out_last = 0.

Test Plan:
- Full frame, log_n_cfg = 3, in_data 10..17 streamed with out_ready = 1 → out_data 10,14,12,16,11,15,13,17. out_last only on 17. in_ready low for exactly 8 cycles.
- log_n_cfg = 2, inputs 0xA0..0xA3 → outputs 0xA0,0xA2,0xA1,0xA3 with out_last on 0xA3. Then a frame with log_n_cfg = 1, inputs 5,6 → outputs 5,6.
- Clamp: log_n_cfg = 0 and log_n_cfg = 7 each behave as an 8-word frame. log_n_cfg changed to 1 after word 3 has no effect.
- Backpressure: out_ready toggled 1,0,0,1,… with random in_valid gaps → same order as the first scenario. out_data stable during stalls. No input is accepted while in DRAIN.
- Reset mid-operation: rst_n asserted after 5 inputs and again after 3 outputs → in_ready = 1 and out_valid = 0 immediately. The next full frame 20..27 gives 20,24,22,26,21,25,23,27.
- Back-to-back: two 8-word frames with in_valid = 1 continuously → the second frame's first word is accepted the cycle after the first frame's out_last handshake.
